// File: rtl/pc_fetch_stage.sv
// ============================================================================
// pc_fetch_stage
//
// Instruction-fetch stage. Owns the architectural PC register, presents it to
// the (combinationally read) instruction memory and the next-PC logic, and
// captures PC + instruction into the IF/ID pipeline register. Supports stall,
// flush and a halt-on-branch-to-self state machine (BOOT -> RUN -> HALT).
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   When defined, a misaligned pc_next (low two bits non-zero) is refused:
//   the PC holds, a sticky fetch_fault is raised and fetch halts. A flush
//   cannot leave HALT while the fault is set; only reset clears it.
//   When undefined, fetch_fault is tied 0 and pc_next is loaded unchanged.
//
// Ports:
//   clk          in   1   clock, all state updates on the rising edge
//   reset        in   1   synchronous active-high reset, wins over everything
//   pc_next      in  64   next PC from the next-PC calculation
//   stall        in   1   hold PC and IF/ID
//   flush        in   1   invalidate the IF/ID slot (redirect from downstream)
//   imem_instr   in  32   instruction at address pc
//   pc           out 64   current PC
//   if_id_pc     out 64   PC of the instruction held in IF/ID
//   if_id_instr  out 32   instruction held in IF/ID
//   if_id_valid  out  1   IF/ID holds a real instruction
//   halted       out  1   fetch is in the HALT state
//   fetch_fault  out  1   sticky misaligned-PC flag
// ============================================================================
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter logic [31:0] HALT_INSTR = 32'h14000000,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_next,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_instr,
    output logic [63:0] pc,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        halted_q, halted_d;
    logic        load_pc;
    logic        halt_locked;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault_q, fetch_fault_d;

    // A latched alignment fault pins fetch in HALT until reset.
    assign halt_locked = fetch_fault_q;
`else
    assign halt_locked = 1'b0;
`endif

    // Next-state logic. Everything holds by default; each state decides
    // whether the slot is refilled, invalidated or left alone, and raises
    // load_pc when the PC should take pc_next. The PC load itself is applied
    // once at the end so the optional alignment check has a single place to
    // veto it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        load_pc       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_fault_d = fetch_fault_q;
`endif

        case (state_q)
            BOOT: begin
                // One dead cycle after reset; stall and flush are ignored.
                state_d = RUN;
            end

            RUN: begin
                if (flush) begin
                    // Flush owns the slot even when a stall is also pending;
                    // the stall only keeps the PC from advancing.
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    load_pc       = !stall;
                end else if (!stall) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_instr;
                    if_id_valid_d = 1'b1;
                    // Branch-to-self: keep the instruction but stop fetching.
                    if (imem_instr == HALT_INSTR) begin
                        state_d = HALT;
                    end else begin
                        load_pc = 1'b1;
                    end
                end
            end

            HALT: begin
                if (flush && !halt_locked) begin
                    // An older branch resolved downstream redirects fetch.
                    load_pc       = 1'b1;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    state_d       = RUN;
                end else if (!stall) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        if (load_pc) begin
            pc_d = pc_next;
        end

`ifdef FETCH_ALIGN_CHECK_EN
        // Refuse a misaligned target: keep the old PC, poison the slot and
        // park in HALT with the sticky fault raised.
        if (load_pc && (pc_next[1:0] != 2'b00)) begin
            pc_d          = pc_q;
            fetch_fault_d = 1'b1;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            state_d       = HALT;
        end
`endif

        halted_d = (state_d == HALT);
    end

    // State register with synchronous reset. halted is registered alongside
    // the state so it always equals (state == HALT) without a decode path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'd0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            halted_q      <= halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault_q <= fetch_fault_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// ============================================================================
// tb_pc_fetch_stage
//
// Directed bench for pc_fetch_stage. The next-PC logic is modelled as pc+4
// unless a vector overrides it, and the instruction memory returns pc[31:0]
// unless a vector injects the halt encoding. Every step applies one vector,
// waits for the rising edge and samples 1 time unit later against
// hand-computed expectations.
// ============================================================================
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP  = 32'hD503201F;
    localparam logic [31:0] HALT = 32'h14000000;

    logic        clk;
    logic        reset;
    logic [63:0] pc_next;
    logic        stall;
    logic        flush;
    logic [31:0] imem_instr;
    logic [63:0] pc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_fault;

    logic        use_override;
    logic [63:0] override_pc;
    logic        inject_halt;

    int checks;
    int errors;

    pc_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_next     (pc_next),
        .stall       (stall),
        .flush       (flush),
        .imem_instr  (imem_instr),
        .pc          (pc),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_fault (fetch_fault)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Next-PC and instruction-memory models.
    assign pc_next    = use_override ? override_pc : (pc + 64'd4);
    assign imem_instr = inject_halt ? HALT : pc[31:0];

    // Drive one vector, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic ovr, input logic [63:0] ovr_pc,
                                 input logic hlt);
        reset        = r;
        stall        = s;
        flush        = f;
        use_override = ovr;
        override_pc  = ovr_pc;
        inject_halt  = hlt;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check the full visible state in one call.
    task automatic checkAll(input string tag, input logic [63:0] exp_pc,
                            input logic [63:0] exp_if_pc, input logic [31:0] exp_instr,
                            input logic exp_valid, input logic exp_halted);
        checkOutput({tag, ".pc"},       pc,                  exp_pc);
        checkOutput({tag, ".if_pc"},    if_id_pc,            exp_if_pc);
        checkOutput({tag, ".instr"},    {32'd0, if_id_instr}, {32'd0, exp_instr});
        checkOutput({tag, ".valid"},    {63'd0, if_id_valid}, {63'd0, exp_valid});
        checkOutput({tag, ".halted"},   {63'd0, halted},      {63'd0, exp_halted});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        use_override = 1'b0; override_pc = 64'd0; inject_halt = 1'b0;

        // Reset, BOOT, sequential fetch.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkAll("reset", 64'h0, 64'h0, NOP, 0, 0);
        checkOutput("reset.fault", {63'd0, fetch_fault}, 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("boot", 64'h0, 64'h0, NOP, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("seq0", 64'h4, 64'h0, 32'h0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("seq1", 64'h8, 64'h4, 32'h4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("seq3", 64'h10, 64'hC, 32'hC, 1, 0);

        // Stall for three cycles at pc=0x10.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkAll("stall", 64'h10, 64'hC, 32'hC, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("unstall", 64'h14, 64'h10, 32'h10, 1, 0);

        // Advance to 0x20, then flush alone.
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("at20.pc", pc, 64'h20);
        applyStimulus(0, 0, 1, 1, 64'h100, 0);
        checkAll("flush", 64'h100, 64'h20, NOP, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("postflush", 64'h104, 64'h100, 32'h100, 1, 0);

        // Flush with stall: slot invalidated, pc holds.
        applyStimulus(0, 1, 1, 1, 64'h300, 0);
        checkOutput("flushstall.pc",    pc,                   64'h104);
        checkOutput("flushstall.valid", {63'd0, if_id_valid}, 64'd0);
        checkOutput("flushstall.instr", {32'd0, if_id_instr}, {32'd0, NOP});

        // Redirect to 0x40 and hit the branch-to-self there.
        applyStimulus(0, 0, 0, 1, 64'h40, 0);
        checkAll("to40", 64'h40, 64'h104, 32'h104, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkAll("halt", 64'h40, 64'h40, HALT, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkAll("halt2", 64'h40, 64'h40, NOP, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkAll("haltstall", 64'h40, 64'h40, NOP, 0, 1);
        applyStimulus(0, 0, 1, 1, 64'h80, 1);
        checkAll("haltflush", 64'h80, 64'h40, NOP, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("resume", 64'h84, 64'h80, 32'h80, 1, 0);

        // Reset while halted.
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("halt3.halted", {63'd0, halted}, 64'd1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkAll("rst_halt", 64'h0, 64'h0, NOP, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("rst_halt_boot", 64'h0, 64'h0, NOP, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("rst_halt_run", 64'h4, 64'h0, 32'h0, 1, 0);

        // Reset during a stall; flush in BOOT must be ignored.
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("stall2.pc", pc, 64'h4);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkAll("rst_stall", 64'h0, 64'h0, NOP, 0, 0);
        applyStimulus(0, 0, 1, 1, 64'h200, 0);
        checkAll("boot_flush", 64'h0, 64'h0, NOP, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("rst_stall_run", 64'h4, 64'h0, 32'h0, 1, 0);

        // Misaligned pc_next at pc=0x100.
        applyStimulus(0, 0, 0, 1, 64'h100, 0);
        checkOutput("at100.pc", pc, 64'h100);
        applyStimulus(0, 0, 0, 1, 64'h102, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        checkAll("misalign", 64'h100, 64'h100, NOP, 0, 1);
        checkOutput("misalign.fault", {63'd0, fetch_fault}, 64'd1);
        applyStimulus(0, 0, 1, 1, 64'h200, 0);
        checkOutput("faultflush.pc",     pc,                   64'h100);
        checkOutput("faultflush.halted", {63'd0, halted},      64'd1);
        checkOutput("faultflush.fault",  {63'd0, fetch_fault}, 64'd1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("faultrst.fault",  {63'd0, fetch_fault}, 64'd0);
        checkOutput("faultrst.halted", {63'd0, halted},      64'd0);
`else
        checkAll("misalign", 64'h102, 64'h100, 32'h100, 1, 0);
        checkOutput("misalign.fault", {63'd0, fetch_fault}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
